// File: rtl/csr_uart_tx.sv
// CSR-mapped UART transmitter: one CSR address, a one-byte holding register
// feeding an 8N1 shifter, and a registered status read-back.
module csr_uart_tx #(
    parameter logic [11:0] BASE_ADDR  = 12'hbc0,
    parameter int          CLOCK_RATE = 100_000_000,
    parameter int          BAUD_RATE  = 115200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        tx
);

    localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
    localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          tx_q;

    logic [7:0]    hr_q,  hr_d;
    logic          hrf_q, hrf_d;
    logic          ovr_q, ovr_d;
    logic          valid_q;
    logic [31:0]   rdata_q;

    logic          hit;
    logic          wr_hit;
    logic          clr_hit;
    logic          rd_hit;
    logic          bit_last;
    logic          xfer;
    logic [31:0]   status;
    logic          unused_wdata;

    assign hit      = (addr == BASE_ADDR);
    assign wr_hit   = hit && (modify == 3'd1);
    assign clr_hit  = hit && (modify == 3'd3) && wdata[9];
    assign rd_hit   = hit && read;
    assign bit_last = (cnt_q == CNT_LAST);
    // HR moves into the shifter when the line is free or the stop bit is ending.
    assign xfer     = hrf_q && ((state_q == IDLE) || ((state_q == STOP) && bit_last));
    assign status   = {21'b0, (state_q != IDLE), ovr_q, hrf_q, 8'b0};

    // Only wdata[7:0] and wdata[9] carry meaning at this address.
    assign unused_wdata = ^{wdata[31:10], wdata[8]};

    // Holding register and overrun flag next state; overrun beats a clear.
    always_comb begin
        hr_d  = hr_q;
        hrf_d = hrf_q;
        ovr_d = ovr_q;
        if (xfer) begin
            hrf_d = 1'b0;
        end
        if (clr_hit) begin
            ovr_d = 1'b0;
        end
        if (wr_hit) begin
            if (!hrf_q || xfer) begin
                hr_d  = wdata[7:0];
                hrf_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // CSR-side state: holding register, flags and the one-cycle read response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hr_q    <= 8'h00;
            hrf_q   <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            hr_q    <= hr_d;
            hrf_q   <= hrf_d;
            ovr_q   <= ovr_d;
            valid_q <= rd_hit;
            rdata_q <= rd_hit ? status : 32'h0;
        end
    end

    // Serial shifter FSM; tx is updated on the edge that enters each bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 3'd0;
                    if (xfer) begin
                        sh_q    <= hr_q;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_last) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= sh_q[0];
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= sh_q[1];
                            sh_q    <= {1'b0, sh_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        if (xfer) begin
                            sh_q    <= hr_q;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx    = tx_q;
    assign valid = valid_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx at DIVIDER=4: stimulus pushes expected read responses
// and expected frames into queues; monitors decode the DUT outputs and pop.
module tb_csr_uart_tx;

    localparam logic [11:0] BASE = 12'hbc0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        tx;

    typedef struct {
        logic [7:0] b;
        int         start;
    } txe_t;

    txe_t        exp_tx[$];
    logic [31:0] exp_rd[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    csr_uart_tx #(
        .BASE_ADDR (BASE),
        .CLOCK_RATE(4),
        .BAUD_RATE (1)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .read  (read),
        .modify(modify),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .valid (valid),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s value=%h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic rd, input logic [2:0] md, input logic [31:0] wd,
                         input logic [11:0] ad);
        read   = rd;
        modify = md;
        wdata  = wd;
        addr   = ad;
        tick(1);
        read   = 1'b0;
        modify = 3'd0;
        wdata  = 32'h0;
        addr   = BASE;
    endtask

    // Write a byte; off is the expected frame start relative to this cycle.
    task automatic wr_exp(input logic [7:0] b, input int off);
        txe_t e;
        e.b     = b;
        e.start = cyc + off;
        exp_tx.push_back(e);
        do_op(1'b0, 3'd1, {24'h0, b}, BASE);
    endtask

    task automatic wr_drop(input logic [7:0] b);
        do_op(1'b0, 3'd1, {24'h0, b}, BASE);
    endtask

    task automatic rd_exp(input logic [31:0] e);
        exp_rd.push_back(e);
        do_op(1'b1, 3'd0, 32'h0, BASE);
    endtask

    // Read-response monitor.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected_valid", {31'h0, valid}, 32'h0);
            end else begin
                chk("rd_resp", rdata, exp_rd.pop_front());
            end
        end else if (valid !== 1'b0 || rdata !== 32'h0) begin
            chk("rd_idle_zero", rdata, 32'h0);
        end
    end

    // Serial monitor: samples every cycle of each 4-cycle bit of a 40-cycle frame.
    int         m_act = 0;
    int         m_pos;
    int         m_start;
    int         m_ok;
    logic [7:0] m_byte;

    always @(negedge clk) begin
        int   slot;
        txe_t e;
        if (rstn !== 1'b1) begin
            m_act = 0;
        end else if (m_act == 0) begin
            if (tx === 1'b0) begin
                m_act   = 1;
                m_pos   = 1;
                m_start = cyc;
                m_ok    = 1;
                m_byte  = 8'h00;
            end else if (tx !== 1'b1) begin
                chk("tx_idle", {31'h0, tx}, 32'h1);
            end
        end else begin
            slot = m_pos / 4;
            if (slot == 0) begin
                if (tx !== 1'b0) m_ok = 0;
            end else if (slot <= 8) begin
                if (m_pos % 4 == 0) m_byte[slot-1] = tx;
                else if (tx !== m_byte[slot-1]) m_ok = 0;
            end else begin
                if (tx !== 1'b1) m_ok = 0;
            end
            m_pos++;
            if (m_pos == 40) begin
                m_act = 0;
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected_frame", {24'h0, m_byte}, 32'hffffffff);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_frame_timing", m_ok, 32'h1);
                    chk("tx_byte", {24'h0, m_byte}, {24'h0, e.b});
                    chk("tx_start_cycle", m_start, e.start);
                end
            end
        end
    end

    initial begin
        int n;
        rstn   = 1'b0;
        read   = 1'b0;
        modify = 3'd0;
        wdata  = 32'h0;
        addr   = BASE;
        tick(3);
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rstn = 1'b1;
        tick(2);
        rd_exp(32'h0);
        tick(2);

        // Single frame 0x55 from idle.
        wr_exp(8'h55, 2);
        tick(50);

        // Back-to-back frames, no overrun.
        wr_exp(8'h41, 2);
        wr_exp(8'h42, 41);
        rd_exp(32'h500);
        tick(85);
        rd_exp(32'h0);
        tick(2);

        // Overrun: third byte dropped, then clear OVR.
        wr_exp(8'h41, 2);
        wr_exp(8'h42, 41);
        wr_drop(8'h43);
        rd_exp(32'h700);
        do_op(1'b0, 3'd3, 32'h200, BASE);
        rd_exp(32'h500);
        do_op(1'b0, 3'd2, 32'hffffffff, BASE);
        rd_exp(32'h500);
        tick(80);
        rd_exp(32'h0);
        tick(2);

        // Reset during DATA bit 3 aborts the frame.
        wr_exp(8'h3c, 2);
        tick(18);
        exp_tx.delete();
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("abort_tx_high", {31'h0, tx}, 32'h1);
        rd_exp(32'h0);
        tick(2);
        wr_exp(8'ha5, 2);
        tick(45);

        // Foreign address: no response, no state change.
        do_op(1'b1, 3'd1, 32'h77, 12'hbc1);
        chk("foreign_valid", {31'h0, valid}, 32'h0);
        chk("foreign_rdata", rdata, 32'h0);
        tick(3);
        rd_exp(32'h0);
        tick(50);

        n = 0;
        while ((exp_tx.size() != 0 || exp_rd.size() != 0) && n < 500) begin
            tick(1);
            n++;
        end
        chk("tx_queue_drained", exp_tx.size(), 32'h0);
        chk("rd_queue_drained", exp_rd.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_uart_tx.md
CSR_UART_TX -- requirements
Module: csr_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hbc0, CSR address the block responds to.
REQ-002 SHALL have parameter CLOCK_RATE, default 100_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 115200, serial bit rate; DIVIDER = CLOCK_RATE/BAUD_RATE (integer division, at least 2).
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port read  input  1  CSR read strobe from the pipeline.
REQ-007 SHALL have port modify  input  3  CSR op: 0 none, 1 write, 2 set, 3 clear.
REQ-008 SHALL have port wdata  input  32  CSR write operand.
REQ-009 SHALL have port addr  input  12  CSR address.
REQ-010 SHALL have port rdata  output  32  read data; all-zero when not responding, for OR-combining with other responders.
REQ-011 SHALL have port valid  output  1  read response valid; zero when not responding.
REQ-012 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-013 SHALL define hit = (addr == BASE_ADDR); all CSR ops with addr != BASE_ADDR are ignored.
REQ-014 SHALL hold a one-byte holding register (HR) with a full flag, and a shifter with states IDLE, START, DATA, STOP.
REQ-015 SHALL, on modify==1 && hit, accept wdata[7:0] into HR if HR is empty or HR transfers to the shifter in the same cycle; else drop the byte and set the sticky OVR flag.
REQ-016 SHALL treat modify==2 && hit as no-op; modify==3 && hit with wdata[9]==1 clears OVR; modify 3 does not touch HR.
REQ-017 SHALL transfer HR to the shifter on the edge where HR is full and the shifter is IDLE or finishing the last STOP cycle; HR becomes empty at that edge.
REQ-018 SHALL frame as: START (tx=0), 8 DATA bits LSB first, 1 STOP (tx=1); each bit lasts exactly DIVIDER cycles.
REQ-019 SHALL drive tx from a register; a write in cycle N into empty HR with idle shifter gives HR full in N+1 and tx=0 from cycle N+2.
REQ-020 SHALL start the next START bit immediately after the last STOP cycle when HR is full (no idle gap); otherwise return to IDLE with tx=1.
REQ-021 SHALL, on read && hit in cycle N, drive valid=1 and rdata = {21'b0, ACT, OVR, HRF, 8'b0} in cycle N+1 only, status sampled in cycle N (ACT = shifter not IDLE, HRF = HR full).
REQ-022 SHALL drive valid=0 and rdata=0 in every cycle not directly following a read && hit.
REQ-023 SHALL apply a clear of OVR and a simultaneous overrun in the same cycle as set (overrun wins).
REQ-024 SHALL count bit time with a counter of width clog2(DIVIDER) wrapping at DIVIDER-1, and a bit index 0..7 in DATA.

Reset
REQ-025 SHALL, when rstn==0 at a rising edge, set tx=1, valid=0, rdata=0, HR empty, OVR=0, shifter IDLE, counters 0.
REQ-026 SHALL abort any frame in progress on reset; tx is 1 from the cycle after the reset edge.
REQ-027 SHALL ignore all CSR ops in cycles where rstn==0.

Verification (bench uses CLOCK_RATE=4, BAUD_RATE=1, DIVIDER=4)
REQ-028 SHALL check: write 0x55 at cycle N when idle -> tx from N+2 = 0,1,0,1,0,1,0,1,0,1, each for 4 cycles, then stays 1.
REQ-029 SHALL check: writes 0x41 at N and 0x42 at N+1 -> two back-to-back 40-cycle frames with no idle cycle between, OVR stays 0.
REQ-030 SHALL check: writes 0x41, 0x42, 0x43 at N, N+1, N+2 -> 0x43 dropped; read at N+3 gives valid=1, rdata=0x00000700 at N+4.
REQ-031 SHALL check: after REQ-030, modify=3 with wdata=0x200 then read -> rdata=0x00000500; after both frames end, read -> 0x00000000.
REQ-032 SHALL check: rstn=0 for one edge during DATA bit 3 -> tx=1, next read returns 0x00000000, a new write of 0xA5 transmits a correct frame.
REQ-033 SHALL check: read and modify=1 at addr 0xbc1 -> valid=0, rdata=0, tx stays 1, no state change.
